wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Two-master, one-slave arbiter for the pipelined Wishbone instruction/data bus. Port 0 serves the FETCH stage (read-only); port 1 serves the data-memory stage (read/write).
- Grants the shared slave for the full duration of a master's cycle (cyc high). Alternates on contention so neither master starves.
- Tracks outstanding requests per grant and routes acks/data back to the granted master only.

Parameters:
- AW, 16, address width
- DW, 16, data width
- LGDEPTH, 4, width of the outstanding-request counter; max outstanding = 2**LGDEPTH-1

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- m0_cyc_i  in  1  fetch cycle request
- m0_stb_i  in  1  fetch strobe
- m0_addr_i  in  AW  fetch address
- m0_stall_o  out  1  stall to fetch
- m0_ack_o  out  1  ack to fetch
- m0_data_o  out  DW  read data to fetch
- m1_cyc_i  in  1  data-stage cycle request
- m1_stb_i  in  1  data-stage strobe
- m1_we_i  in  1  data-stage write enable
- m1_addr_i  in  AW  data-stage address
- m1_data_i  in  DW  data-stage write data
- m1_stall_o  out  1  stall to data stage
- m1_ack_o  out  1  ack to data stage
- m1_data_o  out  DW  read data to data stage
- s_cyc_o  out  1  slave cycle
- s_stb_o  out  1  slave strobe
- s_we_o  out  1  slave write enable
- s_addr_o  out  AW  slave address
- s_data_o  out  DW  slave write data
- s_stall_i  in  1  slave stall
- s_ack_i  in  1  slave ack
- s_data_i  in  DW  slave read data
- grant_o  out  2  one-hot current grant (bit0 = m0, bit1 = m1); 00 when idle

Behaviour:
- State register: IDLE, GNT0, GNT1. Also last_gnt (1 bit) and outstanding counter cnt (LGDEPTH bits).
- Reset (rst_ni low, async): state=IDLE, last_gnt=1 (m0 wins the first tie), cnt=0.
  - Outputs during reset: s_cyc_o=0, s_stb_o=0, s_we_o=0, grant_o=00, m*_ack_o=0, m*_stall_o=1.
- IDLE:
  - s_cyc_o=0, s_stb_o=0, both stall_o=1, both ack_o=0.
  - Next state: only m0_cyc_i -> GNT0; only m1_cyc_i -> GNT1; both -> grant the port != last_gnt; neither -> IDLE.
  - One cycle of latency from a master's cyc rising to s_cyc_o rising.
- GNTx, combinational pass-through from the granted master:
  - s_cyc_o=mx_cyc_i; s_stb_o=mx_stb_i && !full; s_addr_o from mx.
  - s_we_o=m1_we_i in GNT1, forced 0 in GNT0; s_data_o=m1_data_i in GNT1, 0 in GNT0.
  - mx_stall_o=s_stall_i || full; mx_ack_o=s_ack_i && cnt!=0.
- Read data: mx_data_o=s_data_i for both masters at all times; only the ack is gated.
- Non-granted master: stall_o=1, ack_o=0.
- full = (cnt == 2**LGDEPTH-1).
- Counter update each cycle in GNTx: inc = s_stb_o && !s_stall_i; dec = s_ack_i && cnt!=0.
  - cnt <= cnt + inc - dec; simultaneous inc and dec leaves cnt unchanged.
- Stray ack (s_ack_i with cnt==0): dropped, not forwarded; cnt stays 0.
- Release: granted master drops cyc (s_cyc_o falls the same cycle):
  - cnt <= 0 (outstanding requests abandoned, Wishbone abort semantics).
  - last_gnt <= x.
  - Next state: GNTy if the other master's cyc is high that cycle, else IDLE. Direct handoff, no IDLE bubble.
- Back-to-back request from the same master after release (other master idle): GNTx -> IDLE -> GNTx.
- No preemption: a granted master keeps the bus while its cyc stays high, regardless of the other master's requests.
- grant_o is registered state: GNT0 -> 01, GNT1 -> 10, IDLE -> 00.
- Invariants for formal: grant_o one-hot or zero; s_cyc_o implies grant_o!=0; never both ack_o high; cnt <= 2**LGDEPTH-1; s_stb_o implies s_cyc_o.

Test Plan:
- Reset release, m0 cyc/stb at addr 0x0010, s_stall_i=0, ack after 2 cycles -> s_cyc_o high 1 cycle after m0_cyc_i; grant_o=01; m0_ack_o pulses once; m1_ack_o stays 0; cnt returns 0.
- m0 and m1 assert cyc the same cycle, out of reset -> GNT0 first. m0 drops cyc -> GNT1 the next cycle with no idle cycle; s_we_o follows m1_we_i=1; s_data_o=m1_data_i=0xBEEF.
- Contention repeated 4 times, each master releasing after one transfer -> grants alternate 01,10,01,10.
- LGDEPTH=2, m1 issues 5 strobes, s_stall_i=0, no acks -> after 3 accepted, m1_stall_o=1 and s_stb_o=0. One ack -> one more strobe accepted.
- Spurious s_ack_i in IDLE, and in GNT0 with cnt=0 -> m0_ack_o=0, m1_ack_o=0, cnt stays 0.
- rst_ni pulled low mid-transfer in GNT1 with cnt=2 -> s_cyc_o=0 and grant_o=00 immediately (async); after release, a tie grants m0.

Source files
------------

// File: rtl/wb_arbiter_if.sv
// Bus bundle between the two pipeline masters, the arbiter and the shared Wishbone slave.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface wb_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          m0_cyc_i;
    logic          m0_stb_i;
    logic [AW-1:0] m0_addr_i;
    logic          m0_stall_o;
    logic          m0_ack_o;
    logic [DW-1:0] m0_data_o;

    logic          m1_cyc_i;
    logic          m1_stb_i;
    logic          m1_we_i;
    logic [AW-1:0] m1_addr_i;
    logic [DW-1:0] m1_data_i;
    logic          m1_stall_o;
    logic          m1_ack_o;
    logic [DW-1:0] m1_data_o;

    logic          s_cyc_o;
    logic          s_stb_o;
    logic          s_we_o;
    logic [AW-1:0] s_addr_o;
    logic [DW-1:0] s_data_o;
    logic          s_stall_i;
    logic          s_ack_i;
    logic [DW-1:0] s_data_i;

    logic [1:0]    grant_o;

    modport slave (
        input  m0_cyc_i, m0_stb_i, m0_addr_i,
        input  m1_cyc_i, m1_stb_i, m1_we_i, m1_addr_i, m1_data_i,
        input  s_stall_i, s_ack_i, s_data_i,
        output m0_stall_o, m0_ack_o, m0_data_o,
        output m1_stall_o, m1_ack_o, m1_data_o,
        output s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_data_o,
        output grant_o
    );

    modport master (
        output m0_cyc_i, m0_stb_i, m0_addr_i,
        output m1_cyc_i, m1_stb_i, m1_we_i, m1_addr_i, m1_data_i,
        output s_stall_i, s_ack_i, s_data_i,
        input  m0_stall_o, m0_ack_o, m0_data_o,
        input  m1_stall_o, m1_ack_o, m1_data_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_data_o,
        input  grant_o
    );
endinterface

// File: rtl/wb_arbiter.sv
// Two-master, one-slave pipelined Wishbone arbiter: fetch on port 0, data stage on port 1.
// A grant lasts for the master's whole cycle; ties alternate; acks return only to the owner.
module wb_arbiter #(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int LGDEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    wb_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t               state;
    state_t               next_state;
    logic                 last_gnt;
    logic [LGDEPTH-1:0]   cnt;
    logic                 full;
    logic                 cnt_nz;
    logic                 inc;
    logic                 dec;
    logic                 release_bus;

    assign full   = (cnt == {LGDEPTH{1'b1}});
    assign cnt_nz = (cnt != {LGDEPTH{1'b0}});
    assign inc    = bus.s_stb_o && !bus.s_stall_i;
    assign dec    = bus.s_ack_i && cnt_nz;

    assign release_bus = ((state == GNT0) && !bus.m0_cyc_i) ||
                         ((state == GNT1) && !bus.m1_cyc_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // last_gnt = 1 means port 1 owned the bus most recently, so port 0 wins the next tie.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_gnt <= 1'b1;
            cnt      <= {LGDEPTH{1'b0}};
        end else if (release_bus) begin
            last_gnt <= (state == GNT1);
            cnt      <= {LGDEPTH{1'b0}};
        end else if (state != IDLE) begin
            if (inc && !dec) begin
                cnt <= cnt + LGDEPTH'(1);
            end else if (dec && !inc) begin
                cnt <= cnt - LGDEPTH'(1);
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (bus.m0_cyc_i && bus.m1_cyc_i) begin
                    next_state = last_gnt ? GNT0 : GNT1;
                end else if (bus.m0_cyc_i) begin
                    next_state = GNT0;
                end else if (bus.m1_cyc_i) begin
                    next_state = GNT1;
                end
            end
            GNT0: begin
                if (!bus.m0_cyc_i) begin
                    next_state = bus.m1_cyc_i ? GNT1 : IDLE;
                end
            end
            GNT1: begin
                if (!bus.m1_cyc_i) begin
                    next_state = bus.m0_cyc_i ? GNT0 : IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Strobe is also qualified by cyc so s_stb_o can never be seen without s_cyc_o.
    always_comb begin
        bus.s_cyc_o    = 1'b0;
        bus.s_stb_o    = 1'b0;
        bus.s_we_o     = 1'b0;
        bus.s_addr_o   = {AW{1'b0}};
        bus.s_data_o   = {DW{1'b0}};
        bus.m0_stall_o = 1'b1;
        bus.m0_ack_o   = 1'b0;
        bus.m1_stall_o = 1'b1;
        bus.m1_ack_o   = 1'b0;
        bus.grant_o    = 2'b00;
        case (state)
            GNT0: begin
                bus.s_cyc_o    = bus.m0_cyc_i;
                bus.s_stb_o    = bus.m0_cyc_i && bus.m0_stb_i && !full;
                bus.s_addr_o   = bus.m0_addr_i;
                bus.m0_stall_o = bus.s_stall_i || full;
                bus.m0_ack_o   = bus.s_ack_i && cnt_nz;
                bus.grant_o    = 2'b01;
            end
            GNT1: begin
                bus.s_cyc_o    = bus.m1_cyc_i;
                bus.s_stb_o    = bus.m1_cyc_i && bus.m1_stb_i && !full;
                bus.s_we_o     = bus.m1_we_i;
                bus.s_addr_o   = bus.m1_addr_i;
                bus.s_data_o   = bus.m1_data_i;
                bus.m1_stall_o = bus.s_stall_i || full;
                bus.m1_ack_o   = bus.s_ack_i && cnt_nz;
                bus.grant_o    = 2'b10;
            end
            default: ;
        endcase
    end

    assign bus.m0_data_o = bus.s_data_i;
    assign bus.m1_data_o = bus.s_data_i;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios with literal expectations plus
// randomized traffic, all compared every cycle against an ownership/outstanding-count model.
module tb_wb_arbiter;

    localparam int AW      = 16;
    localparam int DW      = 16;
    localparam int LGDEPTH = 2;
    localparam int MAXOUT  = (1 << LGDEPTH) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    wb_arbiter #(.AW(AW), .DW(DW), .LGDEPTH(LGDEPTH)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int assertions = 0;
    int failures   = 0;

    // Model: who owns the slave (0 none, 1 fetch, 2 data), who owned it last, and
    // how many accepted requests still await an ack.
    int owner = 0;
    int last_owner = 2;
    int outstanding = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic c0, input logic s0, input logic c1, input logic s1, input logic ack);
        bus.m0_cyc_i = c0;
        bus.m0_stb_i = s0;
        bus.m1_cyc_i = c1;
        bus.m1_stb_i = s1;
        bus.s_ack_i  = ack;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.s_stall_i = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin : model
        logic gcyc;
        logic gstb;
        logic full;
        logic accept;
        logic ack_ok;
        if (!rst_n) begin
            checkOutput("rst_s_cyc", 32'(bus.s_cyc_o), 32'd0);
            checkOutput("rst_s_stb", 32'(bus.s_stb_o), 32'd0);
            checkOutput("rst_s_we", 32'(bus.s_we_o), 32'd0);
            checkOutput("rst_grant", 32'(bus.grant_o), 32'd0);
            checkOutput("rst_acks", 32'({bus.m1_ack_o, bus.m0_ack_o}), 32'd0);
            checkOutput("rst_stalls", 32'({bus.m1_stall_o, bus.m0_stall_o}), 32'd3);
            owner = 0;
            last_owner = 2;
            outstanding = 0;
        end else begin
            checkOutput("m0_rdata", 32'(bus.m0_data_o), 32'(bus.s_data_i));
            checkOutput("m1_rdata", 32'(bus.m1_data_o), 32'(bus.s_data_i));
            if (owner == 0) begin
                checkOutput("idle_s_cyc", 32'(bus.s_cyc_o), 32'd0);
                checkOutput("idle_s_stb", 32'(bus.s_stb_o), 32'd0);
                checkOutput("idle_s_we", 32'(bus.s_we_o), 32'd0);
                checkOutput("idle_grant", 32'(bus.grant_o), 32'd0);
                checkOutput("idle_acks", 32'({bus.m1_ack_o, bus.m0_ack_o}), 32'd0);
                checkOutput("idle_stalls", 32'({bus.m1_stall_o, bus.m0_stall_o}), 32'd3);
                if (bus.m0_cyc_i && bus.m1_cyc_i) owner = (last_owner == 2) ? 1 : 2;
                else if (bus.m0_cyc_i) owner = 1;
                else if (bus.m1_cyc_i) owner = 2;
            end else begin
                gcyc   = (owner == 1) ? bus.m0_cyc_i : bus.m1_cyc_i;
                gstb   = (owner == 1) ? bus.m0_stb_i : bus.m1_stb_i;
                full   = (outstanding == MAXOUT);
                accept = gcyc && gstb && !full;
                ack_ok = bus.s_ack_i && (outstanding > 0);
                checkOutput("s_cyc", 32'(bus.s_cyc_o), 32'(gcyc));
                checkOutput("s_stb", 32'(bus.s_stb_o), 32'(accept));
                checkOutput("grant", 32'(bus.grant_o), (owner == 1) ? 32'd1 : 32'd2);
                if (owner == 1) begin
                    checkOutput("s_addr", 32'(bus.s_addr_o), 32'(bus.m0_addr_i));
                    checkOutput("s_we", 32'(bus.s_we_o), 32'd0);
                    checkOutput("s_wdata", 32'(bus.s_data_o), 32'd0);
                    checkOutput("m0_stall", 32'(bus.m0_stall_o), 32'(bus.s_stall_i || full));
                    checkOutput("m0_ack", 32'(bus.m0_ack_o), 32'(ack_ok));
                    checkOutput("m1_stall", 32'(bus.m1_stall_o), 32'd1);
                    checkOutput("m1_ack", 32'(bus.m1_ack_o), 32'd0);
                end else begin
                    checkOutput("s_addr", 32'(bus.s_addr_o), 32'(bus.m1_addr_i));
                    checkOutput("s_we", 32'(bus.s_we_o), 32'(bus.m1_we_i));
                    checkOutput("s_wdata", 32'(bus.s_data_o), 32'(bus.m1_data_i));
                    checkOutput("m1_stall", 32'(bus.m1_stall_o), 32'(bus.s_stall_i || full));
                    checkOutput("m1_ack", 32'(bus.m1_ack_o), 32'(ack_ok));
                    checkOutput("m0_stall", 32'(bus.m0_stall_o), 32'd1);
                    checkOutput("m0_ack", 32'(bus.m0_ack_o), 32'd0);
                end
                if (!gcyc) begin
                    last_owner = owner;
                    outstanding = 0;
                    if (owner == 1) owner = bus.m1_cyc_i ? 2 : 0;
                    else owner = bus.m0_cyc_i ? 1 : 0;
                end else begin
                    outstanding = outstanding + ((accept && !bus.s_stall_i) ? 1 : 0) - (ack_ok ? 1 : 0);
                end
            end
        end
    end

    initial begin : stimulus
        int accepted;
        logic [1:0] exp_grant [4];
        exp_grant[0] = 2'b01;
        exp_grant[1] = 2'b10;
        exp_grant[2] = 2'b01;
        exp_grant[3] = 2'b10;

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.m0_addr_i = '0;
        bus.m1_we_i   = 1'b0;
        bus.m1_addr_i = '0;
        bus.m1_data_i = '0;
        bus.s_stall_i = 1'b0;
        bus.s_data_i  = 16'h1234;
        step();
        step();
        rst_n = 1'b1;

        // Single fetch read: one-cycle grant latency, ack two cycles after the strobe.
        bus.m0_addr_i = 16'h0010;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("t1_no_cyc_yet", 32'(bus.s_cyc_o), 32'd0);
        step();
        @(negedge clk);
        checkOutput("t1_s_cyc", 32'(bus.s_cyc_o), 32'd1);
        checkOutput("t1_grant", 32'(bus.grant_o), 32'd1);
        checkOutput("t1_s_addr", 32'(bus.s_addr_o), 32'h0010);
        step();
        bus.m0_stb_i = 1'b0;
        step();
        bus.s_ack_i = 1'b1;
        @(negedge clk);
        checkOutput("t1_m0_ack", 32'(bus.m0_ack_o), 32'd1);
        checkOutput("t1_m1_ack", 32'(bus.m1_ack_o), 32'd0);
        step();
        bus.s_ack_i = 1'b0;
        @(negedge clk);
        checkOutput("t1_ack_once", 32'(bus.m0_ack_o), 32'd0);
        bus.m0_cyc_i = 1'b0;
        step();
        step();

        // Tie out of reset goes to fetch, then direct handoff to the data stage.
        doReset();
        bus.m1_we_i   = 1'b1;
        bus.m1_data_i = 16'hBEEF;
        bus.m1_addr_i = 16'h0200;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("t2_idle_grant", 32'(bus.grant_o), 32'd0);
        step();
        @(negedge clk);
        checkOutput("t2_grant0", 32'(bus.grant_o), 32'd1);
        checkOutput("t2_we_forced0", 32'(bus.s_we_o), 32'd0);
        step();
        bus.m0_cyc_i = 1'b0;
        @(negedge clk);
        checkOutput("t2_cyc_falls", 32'(bus.s_cyc_o), 32'd0);
        step();
        @(negedge clk);
        checkOutput("t2_grant1", 32'(bus.grant_o), 32'd2);
        checkOutput("t2_s_we", 32'(bus.s_we_o), 32'd1);
        checkOutput("t2_s_data", 32'(bus.s_data_o), 32'hBEEF);
        bus.m1_cyc_i = 1'b0;
        step();
        step();

        // Persistent contention: each owner does one transfer and releases.
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput($sformatf("t3_grant%0d", i), 32'(bus.grant_o), 32'(exp_grant[i]));
            step();
            if (i % 2 == 0) bus.m0_stb_i = 1'b1; else bus.m1_stb_i = 1'b1;
            step();
            bus.m0_stb_i = 1'b0;
            bus.m1_stb_i = 1'b0;
            bus.s_ack_i  = 1'b1;
            step();
            bus.s_ack_i = 1'b0;
            if (i % 2 == 0) bus.m0_cyc_i = 1'b0; else bus.m1_cyc_i = 1'b0;
            step();
            bus.m0_cyc_i = 1'b1;
            bus.m1_cyc_i = 1'b1;
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        step();

        // Outstanding limit: only MAXOUT strobes pass until an ack frees a slot.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        accepted = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (bus.s_stb_o && !bus.s_stall_i) accepted++;
            if (k == 3) begin
                checkOutput("t4_full_stall", 32'(bus.m1_stall_o), 32'd1);
                checkOutput("t4_full_no_stb", 32'(bus.s_stb_o), 32'd0);
            end
            step();
        end
        checkOutput("t4_accepted", 32'(accepted), 32'd3);
        bus.s_ack_i = 1'b1;
        @(negedge clk);
        checkOutput("t4_ack", 32'(bus.m1_ack_o), 32'd1);
        step();
        bus.s_ack_i = 1'b0;
        @(negedge clk);
        checkOutput("t4_one_more", 32'(bus.s_stb_o), 32'd1);
        checkOutput("t4_unstalled", 32'(bus.m1_stall_o), 32'd0);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        step();

        // Stray acks in IDLE and in a fresh grant are dropped without disturbing the count.
        bus.s_ack_i = 1'b1;
        @(negedge clk);
        checkOutput("t5_idle_acks", 32'({bus.m1_ack_o, bus.m0_ack_o}), 32'd0);
        bus.m0_cyc_i = 1'b1;
        step();
        @(negedge clk);
        checkOutput("t5_gnt_acks", 32'({bus.m1_ack_o, bus.m0_ack_o}), 32'd0);
        step();
        bus.s_ack_i = 1'b0;
        @(negedge clk);
        checkOutput("t5_not_full", 32'(bus.m0_stall_o), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        step();

        // Asynchronous reset mid-transfer, then a tie must go to fetch again.
        bus.m1_cyc_i = 1'b1;
        step();
        bus.m1_stb_i = 1'b1;
        step();
        step();
        bus.m1_stb_i = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_async_cyc", 32'(bus.s_cyc_o), 32'd0);
        checkOutput("t6_async_grant", 32'(bus.grant_o), 32'd0);
        bus.m0_cyc_i = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        @(negedge clk);
        checkOutput("t6_tie_to_m0", 32'(bus.grant_o), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        step();

        // Randomized Wishbone-legal traffic, checked only by the model.
        for (int n = 0; n < 2000; n++) begin
            if (bus.m0_cyc_i) bus.m0_cyc_i = ($urandom_range(0, 7) != 0);
            else bus.m0_cyc_i = ($urandom_range(0, 3) == 0);
            if (bus.m1_cyc_i) bus.m1_cyc_i = ($urandom_range(0, 7) != 0);
            else bus.m1_cyc_i = ($urandom_range(0, 3) == 0);
            bus.m0_stb_i  = bus.m0_cyc_i && ($urandom_range(0, 1) == 1);
            bus.m1_stb_i  = bus.m1_cyc_i && ($urandom_range(0, 1) == 1);
            bus.m1_we_i   = ($urandom_range(0, 1) == 1);
            bus.m0_addr_i = 16'($urandom);
            bus.m1_addr_i = 16'($urandom);
            bus.m1_data_i = 16'($urandom);
            bus.s_stall_i = ($urandom_range(0, 3) == 0);
            bus.s_ack_i   = ($urandom_range(0, 2) == 0);
            bus.s_data_i  = 16'($urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
